// File: rtl/audio_dma_if.sv
// Request/ack handshake between the audio mixer and this responder, plus the
// VRAM and tile-memory read ports it drives.
interface audio_dma_if #(
  parameter int VRAM_W      = 16,
  parameter int TILE_ADDR_W = 12
);
  logic                   audio_req_i;
  logic                   audio_tile_i;
  logic [VRAM_W-1:0]      audio_addr_i;
  logic                   audio_ack_o;
  logic [15:0]            audio_word_o;
  logic                   vram_idle_i;
  logic                   vram_sel_o;
  logic [VRAM_W-1:0]      vram_addr_o;
  logic [15:0]            vram_data_i;
  logic                   tile_idle_i;
  logic                   tile_sel_o;
  logic [TILE_ADDR_W-1:0] tile_addr_o;
  logic [15:0]            tile_data_i;
  logic                   vram_steal_o;
  logic                   tile_steal_o;
  logic [7:0]             starve_cnt_o;

  modport slave (
    input  audio_req_i, audio_tile_i, audio_addr_i,
    input  vram_idle_i, vram_data_i, tile_idle_i, tile_data_i,
    output audio_ack_o, audio_word_o,
    output vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o,
    output vram_steal_o, tile_steal_o, starve_cnt_o
  );

  modport master (
    output audio_req_i, audio_tile_i, audio_addr_i,
    output vram_idle_i, vram_data_i, tile_idle_i, tile_data_i,
    input  audio_ack_o, audio_word_o,
    input  vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o,
    input  vram_steal_o, tile_steal_o, starve_cnt_o
  );
endinterface

// File: rtl/audio_dma_responder.sv
// Memory-side responder for the audio sample DMA: one latched request, one read
// from VRAM or tile memory, one-cycle ack; steals a slot when audio is starved.
//
// state  | meaning
// S_IDLE | no request outstanding
// S_REQ  | request latched, waiting for a free slot on the selected memory
// S_WAIT | read strobe issued, counting down the read latency
// S_ACK  | ack and word presented for one cycle
module audio_dma_responder #(
  parameter int VRAM_W      = 16,
  parameter int TILE_ADDR_W = 12,
  parameter int RD_LAT      = 1,
  parameter int STARVE_MAX  = 8
) (
  input  logic        clk,
  input  logic        reset_ni,
  audio_dma_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] L_LAT      = RD_LAT[1:0];
  localparam logic [7:0] L_STARVE   = STARVE_MAX[7:0];
  localparam bit         L_STEAL_EN = (STARVE_MAX > 0);

  state_t                 r_state;
  logic                   r_tile;
  logic [VRAM_W-1:0]      r_addr;
  logic [7:0]             r_wait_cnt;
  logic [1:0]             r_lat_cnt;
  logic                   r_stolen;
  logic                   r_ack;
  logic [15:0]            r_word;
  logic                   r_vram_sel;
  logic [VRAM_W-1:0]      r_vram_addr;
  logic                   r_tile_sel;
  logic [TILE_ADDR_W-1:0] r_tile_addr;
  logic                   r_vram_steal;
  logic                   r_tile_steal;
  logic [7:0]             r_starve_cnt;

  logic        w_idle;
  logic [15:0] w_data;
  logic [7:0]  w_wait_nxt;
  logic        w_starve;

  // Only the memory chosen at latch time matters; the other idle/data are ignored.
  assign w_idle     = r_tile ? bus.tile_idle_i : bus.vram_idle_i;
  assign w_data     = r_tile ? bus.tile_data_i : bus.vram_data_i;
  assign w_wait_nxt = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_starve   = L_STEAL_EN && (w_wait_nxt >= L_STARVE) && !r_stolen;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= S_IDLE;
      r_tile       <= 1'b0;
      r_addr       <= '0;
      r_wait_cnt   <= '0;
      r_lat_cnt    <= '0;
      r_stolen     <= 1'b0;
      r_ack        <= 1'b0;
      r_word       <= '0;
      r_vram_sel   <= 1'b0;
      r_vram_addr  <= '0;
      r_tile_sel   <= 1'b0;
      r_tile_addr  <= '0;
      r_vram_steal <= 1'b0;
      r_tile_steal <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.audio_req_i) begin
            r_tile     <= bus.audio_tile_i;
            r_addr     <= bus.audio_addr_i;
            r_wait_cnt <= '0;
            r_stolen   <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.audio_req_i) begin
            r_vram_steal <= 1'b0;
            r_tile_steal <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_idle) begin
            if (r_tile) begin
              r_tile_sel  <= 1'b1;
              r_tile_addr <= r_addr[TILE_ADDR_W-1:0];
            end else begin
              r_vram_sel  <= 1'b1;
              r_vram_addr <= r_addr;
            end
            r_lat_cnt <= L_LAT;
            r_state   <= S_WAIT;
          end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_starve) begin
              r_stolen <= 1'b1;
              if (r_tile) r_tile_steal <= 1'b1;
              else        r_vram_steal <= 1'b1;
              if (r_starve_cnt != 8'hFF) r_starve_cnt <= r_starve_cnt + 8'd1;
            end
          end
        end
        S_WAIT: begin
          // Steal is held through the strobe cycle and released once it is done.
          r_vram_sel   <= 1'b0;
          r_tile_sel   <= 1'b0;
          r_vram_addr  <= '0;
          r_tile_addr  <= '0;
          r_vram_steal <= 1'b0;
          r_tile_steal <= 1'b0;
          if (r_lat_cnt == 2'd0) begin
            r_word  <= w_data;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.audio_ack_o  = r_ack;
  assign bus.audio_word_o = r_word;
  assign bus.vram_sel_o   = r_vram_sel;
  assign bus.vram_addr_o  = r_vram_addr;
  assign bus.tile_sel_o   = r_tile_sel;
  assign bus.tile_addr_o  = r_tile_addr;
  assign bus.vram_steal_o = r_vram_steal;
  assign bus.tile_steal_o = r_tile_steal;
  assign bus.starve_cnt_o = r_starve_cnt;
endmodule

// File: tb/tb_audio_dma_responder.sv
// Directed bench for audio_dma_responder: memory model with one-cycle read
// latency and a scoreboard queue of expected words popped on each ack.
module tb_audio_dma_responder;
  logic clk = 1'b0;
  logic reset_ni;
  always #5 clk = ~clk;

  audio_dma_if #(.VRAM_W(16), .TILE_ADDR_W(12)) bus ();

  audio_dma_responder #(
    .VRAM_W(16), .TILE_ADDR_W(12), .RD_LAT(1), .STARVE_MAX(8)
  ) dut (
    .clk(clk),
    .reset_ni(reset_ni),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_acks = 0;
  int n_vsel = 0;
  int n_tsel = 0;
  int last_ack_cyc = -1;
  int first_steal_cyc = -1;
  int c0, a0, v0, t0;
  logic [15:0] last_vram_addr = '0;
  logic [11:0] last_tile_addr = '0;
  logic [15:0] vram_word = '0;
  logic [15:0] tile_word = '0;
  logic        v_sel_d = 1'b0;
  logic        t_sel_d = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {7'b0, bus.audio_ack_o, bus.audio_word_o, bus.vram_sel_o, bus.vram_addr_o,
            bus.tile_sel_o, bus.tile_addr_o, bus.vram_steal_o, bus.tile_steal_o,
            bus.starve_cnt_o};
  endfunction

  // One clock: memory model (data valid only in the cycle after the strobe),
  // event bookkeeping, and scoreboard compare on ack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.vram_data_i = v_sel_d ? vram_word : 16'hDEAD;
    bus.tile_data_i = t_sel_d ? tile_word : 16'hBAD0;
    v_sel_d = bus.vram_sel_o;
    t_sel_d = bus.tile_sel_o;
    if (bus.vram_sel_o) begin
      n_vsel++;
      last_vram_addr = bus.vram_addr_o;
    end
    if (bus.tile_sel_o) begin
      n_tsel++;
      last_tile_addr = bus.tile_addr_o;
    end
    if ((bus.vram_steal_o || bus.tile_steal_o) && first_steal_cyc < 0) first_steal_cyc = cyc;
    if (bus.audio_ack_o) begin
      n_acks++;
      last_ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("ack_with_empty_scoreboard", 64'(exp_q.size()), 64'(1));
      end else begin
        exp_w = exp_q.pop_front();
        check("ack_word", 64'(bus.audio_word_o), 64'(exp_w));
      end
    end
  endtask

  // Waits for one ack, then drops req on the edge after it.
  task automatic wait_ack(input int bound);
    int start;
    start = n_acks;
    for (int i = 0; i < bound && n_acks == start; i++) tick();
    if (n_acks == start) check("ack_timeout", 64'(n_acks - start), 64'(1));
    tick();
    bus.audio_req_i = 1'b0;
  endtask

  initial begin
    reset_ni         = 1'b0;
    bus.audio_req_i  = 1'b0;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = '0;
    bus.vram_idle_i  = 1'b0;
    bus.tile_idle_i  = 1'b0;
    bus.vram_data_i  = '0;
    bus.tile_data_i  = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.audio_req_i  = 1'($urandom_range(0, 1));
      bus.audio_tile_i = 1'($urandom_range(0, 1));
      bus.audio_addr_i = 16'($urandom);
      bus.vram_idle_i  = 1'($urandom_range(0, 1));
      bus.tile_idle_i  = 1'($urandom_range(0, 1));
      #1;
      check("reset_outputs_zero", all_outs(), 64'(0));
    end
    bus.audio_req_i = 1'b0;
    tick();
    reset_ni = 1'b1;
    repeat (4) tick();
    check("post_reset_no_ack", 64'(n_acks), 64'(0));
    check("post_reset_outputs_zero", all_outs(), 64'(0));

    // 2: VRAM read, minimum latency
    bus.vram_idle_i  = 1'b1;
    bus.tile_idle_i  = 1'b1;
    vram_word        = 16'hBEEF;
    v0               = n_vsel;
    c0               = cyc;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h1234;
    exp_q.push_back(16'hBEEF);
    wait_ack(20);
    check("t2_latency", 64'(last_ack_cyc - c0), 64'(4));
    check("t2_vram_addr", 64'(last_vram_addr), 64'(16'h1234));
    check("t2_vsel_count", 64'(n_vsel - v0), 64'(1));
    check("t2_ack_one_cycle", 64'(bus.audio_ack_o), 64'(0));
    repeat (3) tick();
    check("t2_word_hold", 64'(bus.audio_word_o), 64'(16'hBEEF));

    // 3: tile read; unselected idle low and post-latch input changes must be ignored
    bus.vram_idle_i  = 1'b0;
    tile_word        = 16'h5A5A;
    v0               = n_vsel;
    t0               = n_tsel;
    c0               = cyc;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b1;
    bus.audio_addr_i = 16'hF123;
    exp_q.push_back(16'h5A5A);
    tick();
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0000;
    wait_ack(20);
    check("t3_latency", 64'(last_ack_cyc - c0), 64'(4));
    check("t3_tile_addr", 64'(last_tile_addr), 64'(12'h123));
    check("t3_tsel_count", 64'(n_tsel - t0), 64'(1));
    check("t3_no_vram_sel", 64'(n_vsel - v0), 64'(0));

    // 4: starvation on VRAM
    bus.vram_idle_i  = 1'b0;
    vram_word        = 16'h1357;
    first_steal_cyc  = -1;
    c0               = cyc;
    bus.audio_req_i  = 1'b1;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0042;
    exp_q.push_back(16'h1357);
    repeat (20) tick();
    check("t4_steal_rise_cycle", 64'(first_steal_cyc - c0), 64'(9));
    check("t4_vram_steal_held", 64'(bus.vram_steal_o), 64'(1));
    check("t4_tile_steal_low", 64'(bus.tile_steal_o), 64'(0));
    check("t4_starve_cnt_once", 64'(bus.starve_cnt_o), 64'(1));
    bus.vram_idle_i = 1'b1;
    wait_ack(20);
    check("t4_steal_cleared", 64'(bus.vram_steal_o), 64'(0));
    check("t4_vram_addr", 64'(last_vram_addr), 64'(16'h0042));
    check("t4_starve_cnt_after", 64'(bus.starve_cnt_o), 64'(1));

    // 5: mixer-style back-to-back, alternating memories
    a0 = n_acks;
    v0 = n_vsel;
    t0 = n_tsel;
    for (int k = 0; k < 4; k++) begin
      vram_word        = 16'hA000 + 16'(k * 17);
      tile_word        = 16'hC000 + 16'(k * 29);
      bus.audio_tile_i = 1'(k % 2);
      bus.audio_addr_i = 16'h0100 * 16'(k) + 16'(k);
      exp_q.push_back((k % 2 == 1) ? tile_word : vram_word);
      bus.audio_req_i = 1'b1;
      wait_ack(20);
    end
    repeat (3) tick();
    check("t5_ack_count", 64'(n_acks - a0), 64'(4));
    check("t5_sel_count", 64'((n_vsel - v0) + (n_tsel - t0)), 64'(4));
    check("t5_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    // 6: async reset during WAIT
    vram_word        = 16'h7777;
    bus.audio_tile_i = 1'b0;
    bus.audio_addr_i = 16'h0777;
    bus.audio_req_i  = 1'b1;
    exp_q.push_back(16'h7777);
    for (int i = 0; i < 10 && !bus.vram_sel_o; i++) tick();
    check("t6_reached_sel", 64'(bus.vram_sel_o), 64'(1));
    reset_ni = 1'b0;
    #1;
    check("t6_async_reset_outputs", all_outs(), 64'(0));
    exp_q.delete();
    bus.audio_req_i = 1'b0;
    repeat (2) tick();
    reset_ni = 1'b1;
    a0 = n_acks;
    repeat (10) tick();
    check("t6_no_ack_after_reset", 64'(n_acks - a0), 64'(0));

    // 6b: 300 forced steals (request aborted after each steal)
    bus.vram_idle_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.audio_req_i = 1'b1;
      for (int j = 0; j < 20 && !bus.vram_steal_o; j++) tick();
      if (!bus.vram_steal_o) check("t6_steal_timeout", 64'(bus.vram_steal_o), 64'(1));
      bus.audio_req_i = 1'b0;
      repeat (2) tick();
      if (i == 99) check("t6_starve_cnt_100", 64'(bus.starve_cnt_o), 64'(100));
    end
    check("t6_starve_cnt_saturated", 64'(bus.starve_cnt_o), 64'(255));
    check("t6_abort_clears_steal", 64'(bus.vram_steal_o), 64'(0));
    check("t6_no_ack_on_abort", 64'(n_acks - a0), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
